// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver: scans DIGITS digits with a blanking gap at each
// slot start and double-buffers the displayed value so updates land only on frame edges.
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD     = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  load_i,
  input  logic                  lzb_en_i,
  input  logic                  en_i,
  output logic [0:7]            seg_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_o,
  output logic                  pending_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx;
  logic [DIGITS-1:0][3:0]   pend_val;
  logic [DIGITS-1:0][3:0]   act_val;
  logic [DIGITS-1:0]        pend_dp;
  logic [DIGITS-1:0]        act_dp;

  logic                     boundary;
  logic                     commit;
  logic                     dark;
  logic                     blank_lead;
  logic                     zero_run;
  logic [DIGITS-1:0]        lead_zero;
  logic [0:6]               lit;
  logic [0:7]               seg_nxt;
  logic [DIGITS-1:0]        an_nxt;

  // Lit-segment pattern, index 0 = a ... 6 = g, active-high.
  function automatic logic [0:6] seg_lit(input logic [3:0] n);
    case (n)
      4'h0:    seg_lit = 7'b1111110;
      4'h1:    seg_lit = 7'b0110000;
      4'h2:    seg_lit = 7'b1101101;
      4'h3:    seg_lit = 7'b1111001;
      4'h4:    seg_lit = 7'b0110011;
      4'h5:    seg_lit = 7'b1011011;
      4'h6:    seg_lit = 7'b1011111;
      4'h7:    seg_lit = 7'b1110000;
      4'h8:    seg_lit = 7'b1111111;
      4'h9:    seg_lit = 7'b1111011;
      4'hA:    seg_lit = 7'b1110111;
      4'hB:    seg_lit = 7'b0011111;
      4'hC:    seg_lit = 7'b1001110;
      4'hD:    seg_lit = 7'b0111101;
      4'hE:    seg_lit = 7'b1001111;
      default: seg_lit = 7'b1000111;
    endcase
  endfunction

  assign boundary = (cnt == CW'(SCAN_DIV - 1)) && (idx == IW'(DIGITS - 1));
  assign commit   = boundary && pending_o;

  // lead_zero[k] is set when every active nibble from the top down to k is zero.
  always_comb begin
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run & (act_val[k] == 4'd0);
      lead_zero[k] = zero_run;
    end
  end

  always_comb begin
    dark       = (cnt < CW'(DEAD)) || !en_i;
    blank_lead = lzb_en_i && (idx != '0) && lead_zero[idx];
    lit        = blank_lead ? 7'b0000000 : seg_lit(act_val[idx]);
    seg_nxt    = {~lit, ~act_dp[idx]};
    an_nxt     = ~(DIGITS'(1) << idx);
    if (dark) begin
      seg_nxt = '1;
      an_nxt  = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      act_val   <= '0;
      act_dp    <= '0;
      pending_o <= 1'b0;
      frame_o   <= 1'b0;
      seg_o     <= '1;
      an_o      <= '1;
    end else begin
      if (cnt == CW'(SCAN_DIV - 1)) begin
        cnt <= '0;
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (load_i) begin
        pend_val <= value_i;
        pend_dp  <= dp_i;
      end

      // A load on the commit cycle refills pending, so pending stays set.
      if (commit) begin
        act_val   <= pend_val;
        act_dp    <= pend_dp;
        pending_o <= load_i;
      end else if (load_i) begin
        pending_o <= 1'b1;
      end

      frame_o <= commit;
      seg_o   <= seg_nxt;
      an_o    <= an_nxt;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot (legal >= 2).
REQ-003 SHALL have parameter DEAD, default 500, anti-ghost blank cycles at the start of each slot (legal 0..SCAN_DIV-1).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port value_i, input, 4*DIGITS, hex nibbles; nibble k ([4k+3:4k]) drives digit k, with digit 0 least significant.
REQ-007 SHALL have port dp_i, input, DIGITS, decimal point per digit, 1 = lit.
REQ-008 SHALL have port load_i, input, 1, single-cycle strobe that captures value_i/dp_i.
REQ-009 SHALL have port lzb_en_i, input, 1, leading-zero blanking enable.
REQ-010 SHALL have port en_i, input, 1, display enable.
REQ-011 SHALL have port seg_o, output, [0:7], segments a,b,c,d,e,f,g,dp in index order 0..7, active-low.
REQ-012 SHALL have port an_o, output, DIGITS, digit select, active-low; bit k selects digit k.
REQ-013 SHALL have port frame_o, output, 1, one-cycle pulse when new data becomes active.
REQ-014 SHALL have port pending_o, output, 1, high while loaded data awaits a frame boundary.

Function
REQ-015 SHALL run slot counter cnt 0..SCAN_DIV-1; on wrap, digit index idx SHALL advance 0..DIGITS-1, then wrap to 0.
REQ-016 SHALL define the frame boundary as the cycle with cnt==SCAN_DIV-1 and idx==DIGITS-1.
REQ-017 SHALL, on load_i, write value_i/dp_i into pending registers and set pending_o on the next cycle.
REQ-018 SHALL, at a frame boundary with pending_o=1, copy pending into active registers, clear pending_o, and pulse frame_o for one cycle (the cycle after the boundary).
REQ-019 SHALL, when load_i coincides with a boundary, give active the old pending contents and pending the new value_i, keeping pending_o=1; a repeated load_i SHALL overwrite pending (last wins).
REQ-020 SHALL register seg_o/an_o, reflecting the idx/cnt of the previous cycle (one-cycle latency).
REQ-021 SHALL drive an_o all ones and seg_o 8'hFF while cnt < DEAD.
REQ-022 SHALL otherwise drive an_o with only bit idx low and seg_o with the decoded active digit idx.
REQ-023 SHALL decode lit segments as: 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 abcdefg, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg; dp follows the active dp bit.
REQ-024 SHALL, with lzb_en_i=1, blank segments a-g of digit k>0 when active nibbles DIGITS-1 down to k are all zero; digit 0 is never blanked; dp is unaffected.
REQ-025 SHALL, with en_i=0, drive an_o all ones and seg_o 8'hFF while counters and load/commit continue.
REQ-026 SHALL apply lzb_en_i and en_i live (not shadowed).

Reset
REQ-027 SHALL, on rst, set cnt=0, idx=0, active/pending value and dp to 0, pending_o=0, frame_o=0, seg_o=8'hFF, and an_o all ones; rst SHALL win over load_i in the same cycle.
REQ-028 SHALL, after rst deasserts mid-operation, restart scanning at digit 0 with cnt=0, and discard prior pending data.

Verification (DIGITS=4, SCAN_DIV=4, DEAD=1)
REQ-029 SHALL check: rst, then load_i with value_i=16'h1234, dp_i=0 -> pending_o=1 until first boundary; frame_o pulses once; digit 0 slot gives an_o=4'b1110, seg_o=8'b10011001.
REQ-030 SHALL check: value 16'h0050, lzb_en_i=1 -> digits 3,2 give seg_o=8'hFF, digit 1 gives 8'b01001001, digit 0 gives 8'b00000011; value 16'h0000 -> only digit 0 lit.
REQ-031 SHALL check: first cycle of every slot (registered) -> an_o=4'hF, seg_o=8'hFF; never two an_o bits low.
REQ-032 SHALL check: load 16'hAAAA on the boundary cycle while pending holds 16'h5555 -> active=5555, pending_o stays 1, AAAA is committed at the next boundary.
REQ-033 SHALL check: en_i=0 for 10 cycles mid-frame -> outputs blank and idx keeps advancing; rst mid-slot -> next output slot is digit 0 showing 0.
